// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side arbitration logic.
package fifo_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Modulo increment that also works when n is not a power of two.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first asserted request at or above rr_ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [PW-1:0]   sel,
  output logic            any
);

  // Scan from farthest to nearest so the closest hit to rr_ptr is the last assignment.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NREQ]) begin
        sel = PW'((int'(rr_ptr) + k) % NREQ);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers,
// with burst locking up to MAX_BURST beats and full-flag backpressure.
//
// state  | meaning
// IDLE   | free arbitration from rr_ptr, single beats or burst start
// LOCKED | port held by owner until req_last or MAX_BURST beats
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 16,
  parameter int MAX_BURST = 4,
  localparam int PW       = $clog2(NREQ),
  localparam int CW       = $clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        ack,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [DWIDTH-1:0]      fifo_wr_data,
  output logic [PW-1:0]          owner,
  output logic                   locked
);

  arb_state_e    state;
  logic [PW-1:0] rr_ptr;
  logic [CW-1:0] beat_cnt;
  logic [PW-1:0] pick_sel;
  logic          pick_any;
  logic [PW-1:0] sel;
  logic          cand;
  logic          accept;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .sel    (pick_sel),
    .any    (pick_any)
  );

  // While reset is held the handshake is suppressed even though state already reads IDLE.
  always_comb begin
    sel          = (state == LOCKED) ? owner : pick_sel;
    cand         = (state == LOCKED) ? req[owner] : pick_any;
    accept       = cand & ~fifo_full & rst;
    ack          = '0;
    if (accept) ack[sel] = 1'b1;
    fifo_wr_en   = accept;
    fifo_wr_data = cand ? req_data[sel*DWIDTH +: DWIDTH] : '0;
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      owner    <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          owner    <= sel;
          beat_cnt <= CW'(1);
          if (req_last[sel] || MAX_BURST == 1) begin
            rr_ptr <= PW'(rr_next(int'(sel), NREQ));
          end else begin
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (req_last[owner] || (int'(beat_cnt) + 1 >= MAX_BURST)) begin
            state    <= IDLE;
            rr_ptr   <= PW'(rr_next(int'(owner), NREQ));
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle handshake checks plus a write-data scoreboard.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  ack;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic [1:0]  owner;
  logic        locked;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  fifo_wr_arbiter #(.NREQ(4), .DWIDTH(16), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .req_last     (req_last),
    .ack          (ack),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .owner        (owner),
    .locked       (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i, input logic [15:0] d, input logic l);
    req[i]               = 1'b1;
    req_data[i*16 +: 16] = d;
    req_last[i]          = l;
  endtask

  task automatic drop(input int i);
    req[i]      = 1'b0;
    req_last[i] = 1'b0;
  endtask

  // Called just after a rising edge; checks mid-cycle, then advances to just after the next edge.
  task automatic tick(input logic [3:0] ea, input logic el, input logic [1:0] eo);
    logic [15:0] ed;
    #3;
    chk("ack", 64'(ack), 64'(ea));
    chk("wr_en", 64'(fifo_wr_en), 64'(|ea));
    chk("locked", 64'(locked), 64'(el));
    chk("owner", 64'(owner), 64'(eo));
    if (fifo_wr_en === 1'b1) begin
      ed = 16'hxxxx;
      if (exp_q.size() > 0) ed = exp_q.pop_front();
      chk("wr_data", 64'(fifo_wr_data), 64'(ed));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    req       = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;

    // reset held, then released with nothing requesting
    @(posedge clk);
    #1;
    tick(4'b0000, 1'b0, 2'd0);
    tick(4'b0000, 1'b0, 2'd0);
    tick(4'b0000, 1'b0, 2'd0);
    rst = 1'b1;
    tick(4'b0000, 1'b0, 2'd0);

    // single-beat round robin
    for (int i = 0; i < 4; i++) put(i, 16'h1000 + 16'(i), 1'b1);
    exp_q.push_back(16'h1000); tick(4'b0001, 1'b0, 2'd0);
    exp_q.push_back(16'h1001); tick(4'b0010, 1'b0, 2'd0);
    exp_q.push_back(16'h1002); tick(4'b0100, 1'b0, 2'd1);
    exp_q.push_back(16'h1003); tick(4'b1000, 1'b0, 2'd2);
    exp_q.push_back(16'h1000); tick(4'b0001, 1'b0, 2'd3);
    for (int i = 0; i < 4; i++) drop(i);
    tick(4'b0000, 1'b0, 2'd0);

    // single beat from req3 moves rr_ptr back to 0
    put(3, 16'h3333, 1'b1);
    exp_q.push_back(16'h3333); tick(4'b1000, 1'b0, 2'd0);
    drop(3);

    // burst lock: req0 three beats, req1 waiting throughout
    put(0, 16'h00A0, 1'b0);
    put(1, 16'h00B0, 1'b1);
    exp_q.push_back(16'h00A0); tick(4'b0001, 1'b0, 2'd3);
    put(0, 16'h00A1, 1'b0);
    exp_q.push_back(16'h00A1); tick(4'b0001, 1'b1, 2'd0);
    put(0, 16'h00A2, 1'b1);
    exp_q.push_back(16'h00A2); tick(4'b0001, 1'b1, 2'd0);
    drop(0);
    exp_q.push_back(16'h00B0); tick(4'b0010, 1'b0, 2'd0);
    drop(1);

    // forced release after MAX_BURST beats from req2, req3 waiting
    put(3, 16'h00D0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      put(2, 16'h00C0 + 16'(b), 1'b0);
      exp_q.push_back(16'h00C0 + 16'(b));
      tick(4'b0100, (b != 0), (b == 0) ? 2'd1 : 2'd2);
    end
    put(2, 16'h00C4, 1'b0);
    exp_q.push_back(16'h00D0); tick(4'b1000, 1'b0, 2'd2);
    drop(3);
    put(2, 16'h00C4, 1'b1);
    exp_q.push_back(16'h00C4); tick(4'b0100, 1'b0, 2'd3);
    drop(2);

    // full backpressure in the middle of a req1 burst, req0 queued behind it
    put(1, 16'h00E0, 1'b0);
    exp_q.push_back(16'h00E0); tick(4'b0010, 1'b0, 2'd2);
    put(1, 16'h00E1, 1'b0);
    exp_q.push_back(16'h00E1); tick(4'b0010, 1'b1, 2'd1);
    put(1, 16'h00E2, 1'b0);
    put(0, 16'h00F0, 1'b1);
    fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) tick(4'b0000, 1'b1, 2'd1);
    fifo_full = 1'b0;
    exp_q.push_back(16'h00E2); tick(4'b0010, 1'b1, 2'd1);
    put(1, 16'h00E3, 1'b0);
    exp_q.push_back(16'h00E3); tick(4'b0010, 1'b1, 2'd1);
    drop(1);
    exp_q.push_back(16'h00F0); tick(4'b0001, 1'b0, 2'd1);
    drop(0);
    tick(4'b0000, 1'b0, 2'd0);

    // async reset between edges during beat 2 of a req0 burst
    put(0, 16'h0060, 1'b0);
    exp_q.push_back(16'h0060); tick(4'b0001, 1'b0, 2'd0);
    put(0, 16'h0061, 1'b0);
    #3;
    chk("pre_rst_ack", 64'(ack), 64'(4'b0001));
    chk("pre_rst_locked", 64'(locked), 64'(1'b1));
    rst = 1'b0;
    #1;
    chk("rst_locked", 64'(locked), 64'(1'b0));
    chk("rst_ack", 64'(ack), 64'(4'b0000));
    chk("rst_wr_en", 64'(fifo_wr_en), 64'(1'b0));
    chk("rst_owner", 64'(owner), 64'(2'd0));
    @(posedge clk);
    #1;
    tick(4'b0000, 1'b0, 2'd0);
    rst = 1'b1;
    put(0, 16'h0070, 1'b1);
    put(1, 16'h0071, 1'b1);
    exp_q.push_back(16'h0070); tick(4'b0001, 1'b0, 2'd0);
    drop(0);
    exp_q.push_back(16'h0071); tick(4'b0010, 1'b0, 2'd0);
    drop(1);
    tick(4'b0000, 1'b0, 2'd1);

    chk("sb_leftover", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
